// File: rtl/seg7_disp_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : seg7_disp_arbiter
// Function : Round-robin owner arbiter for a shared 7-segment display with a
//            minimum dwell time; optional blanking via SEG7_ARB_BLANK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_disp_arbiter #(
  parameter int DWELL_CYCLES = 262144
) (
  input  logic         CLK100MHZ,
  input  logic         CPU_RESETN,
  input  logic [2:0]   req,
  input  logic [2:0]   req_mode,
  input  logic [191:0] req_data,
  output logic [2:0]   grant,
  output logic         o_disp_mode,
  output logic [63:0]  o_disp_data,
  output logic         o_busy
);

  localparam logic [1:0]  c_IDLE       = 2'd0;
  localparam logic [1:0]  c_HOLD       = 2'd1;
  localparam logic [1:0]  c_RELEASE    = 2'd2;
  localparam logic [19:0] c_DWELL_LOAD = 20'(DWELL_CYCLES - 1);

  logic [1:0]  r_state;
  logic [1:0]  w_state_next;
  logic [1:0]  r_last_owner;
  logic [19:0] r_cnt;
  logic [1:0]  w_c0;
  logic [1:0]  w_c1;
  logic [1:0]  w_c2;
  logic [1:0]  w_win;
  logic [2:0]  w_win_onehot;
  logic        w_owner_req;
  logic        w_others;
  logic        w_cnt_zero;
  logic [63:0] w_lane;
  logic        w_lane_mode;

  function automatic logic [1:0] f_next_idx(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  // Candidate order starts just after the previous owner and wraps.
  always_comb begin
    w_c0 = f_next_idx(r_last_owner);
    w_c1 = f_next_idx(w_c0);
    w_c2 = f_next_idx(w_c1);
    if (req[w_c0])      w_win = w_c0;
    else if (req[w_c1]) w_win = w_c1;
    else                w_win = w_c2;
    w_win_onehot = 3'b001 << w_win;
  end

  assign w_owner_req = req[r_last_owner];
  assign w_others    = |(req & ~grant);
  assign w_cnt_zero  = (r_cnt == 20'd0);

  always_comb begin
    w_state_next = c_IDLE;
    case (r_state)
      c_HOLD: begin
        if (!w_owner_req || (w_cnt_zero && w_others)) w_state_next = c_RELEASE;
        else                                          w_state_next = c_HOLD;
      end
      default: begin
        if (|req) w_state_next = c_HOLD;
        else      w_state_next = c_IDLE;
      end
    endcase
  end

  always_comb begin
    case (r_last_owner)
      2'd0:    w_lane = req_data[63:0];
      2'd1:    w_lane = req_data[127:64];
      default: w_lane = req_data[191:128];
    endcase
    w_lane_mode = req_mode[r_last_owner];
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      r_state      <= c_IDLE;
      grant        <= 3'b000;
      r_last_owner <= 2'd2;
      r_cnt        <= 20'd0;
    end else begin
      r_state <= w_state_next;
      if (r_state != c_HOLD) begin
        if (|req) begin
          grant        <= w_win_onehot;
          r_last_owner <= w_win;
          r_cnt        <= c_DWELL_LOAD;
        end else begin
          grant <= 3'b000;
        end
      end else begin
        // Break-before-make: grant drops for the whole RELEASE cycle.
        if (w_state_next == c_RELEASE) grant <= 3'b000;
        if (!w_cnt_zero) r_cnt <= r_cnt - 20'd1;
      end
    end
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      o_disp_mode <= 1'b0;
      o_disp_data <= 64'h0;
    end else if (r_state == c_HOLD) begin
      o_disp_mode <= w_lane_mode;
      o_disp_data <= w_lane;
    end else begin
`ifdef SEG7_ARB_BLANK_EN
      o_disp_mode <= 1'b1;
      o_disp_data <= 64'hFFFF_FFFF_FFFF_FFFF;
`else
      o_disp_mode <= o_disp_mode;
      o_disp_data <= o_disp_data;
`endif
    end
  end

  assign o_busy = (r_state == c_HOLD);

endmodule
`default_nettype wire

// File: tb/tb_seg7_disp_arbiter.sv
`default_nettype none
// Testbench for seg7_disp_arbiter: directed scenarios plus random traffic
// checked against an ownership-level reference model (DWELL_CYCLES=4).
module tb_seg7_disp_arbiter;
  localparam int DW = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [2:0]   req;
  logic [2:0]   req_mode;
  logic [191:0] req_data;
  logic [2:0]   grant;
  logic         o_disp_mode;
  logic [63:0]  o_disp_data;
  logic         o_busy;

  int errors = 0;
  int checks = 0;

  int          m_owner;
  int          m_held;
  int          m_last;
  logic        m_mode;
  logic [63:0] m_data;

  always #5 clk = ~clk;

  seg7_disp_arbiter #(.DWELL_CYCLES(DW)) dut (
    .CLK100MHZ  (clk),
    .CPU_RESETN (rst_n),
    .req        (req),
    .req_mode   (req_mode),
    .req_data   (req_data),
    .grant      (grant),
    .o_disp_mode(o_disp_mode),
    .o_disp_data(o_disp_data),
    .o_busy     (o_busy)
  );

  function automatic logic [2:0] exp_grant();
    return (m_owner >= 0) ? (3'b001 << m_owner) : 3'b000;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_held = 0; m_last = 2; m_mode = 1'b0; m_data = 64'h0;
  endtask

  // Ownership view: who holds the display and for how many cycles so far.
  task automatic model_edge();
    int others;
    int w;
    if (m_owner >= 0) begin
      m_data = req_data[64*m_owner +: 64];
      m_mode = req_mode[m_owner];
      others = 0;
      for (int i = 0; i < 3; i++) if (i != m_owner && req[i]) others = 1;
      if (!req[m_owner] || (m_held >= DW && others != 0)) m_owner = -1;
      else m_held++;
    end else begin
`ifdef SEG7_ARB_BLANK_EN
      m_data = 64'hFFFF_FFFF_FFFF_FFFF;
      m_mode = 1'b1;
`endif
      if (req != 3'b000) begin
        w = -1;
        for (int k = 1; k <= 3; k++) if (w < 0 && req[(m_last + k) % 3]) w = (m_last + k) % 3;
        m_owner = w; m_last = w; m_held = 1;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req = 3'b000;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; req = 3'b111;
    #2;
    checks++;
    if (grant !== 3'b000 || o_busy !== 1'b0 || o_disp_mode !== 1'b0 || o_disp_data !== 64'h0) begin
      errors++;
      $display("FAIL reset_state: grant=%b busy=%b mode=%b data=%h, required 000 0 0 0", grant, o_busy, o_disp_mode, o_disp_data);
    end
    do_reset();
  endtask

  task automatic test_single();
    req_data[63:0] = 64'h12345678; req_mode[0] = 1'b0; req = 3'b001;
    step();
    checks++;
    if (grant !== 3'b001 || o_busy !== 1'b1) begin
      errors++; $display("FAIL single_grant: grant=%b busy=%b, required 001 1", grant, o_busy);
    end
    step();
    checks++;
    if (o_disp_data !== 64'h12345678 || o_disp_mode !== 1'b0) begin
      errors++; $display("FAIL single_data: data=%h mode=%b, required 12345678 0", o_disp_data, o_disp_mode);
    end
    req = 3'b000;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (grant !== exp_grant() || o_disp_data !== m_data) begin
        errors++; $display("FAIL single_drop c%0d: grant=%b data=%h, required %b %h", c, grant, o_disp_data, exp_grant(), m_data);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] g_exp;
    do_reset();
    req = 3'b111;
    for (int n = 0; n < 20; n++) begin
      step();
      g_exp = ((n % 5) == 4) ? 3'b000 : (3'b001 << ((n / 5) % 3));
      checks++;
      if (grant !== g_exp || grant !== exp_grant()) begin
        errors++; $display("FAIL round_robin n%0d: grant=%b, required %b", n, grant, g_exp);
      end
    end
    req = 3'b000;
    step(); step();
  endtask

  task automatic test_early_release();
    do_reset();
    req = 3'b010;
    step();
    step();
    checks++;
    if (grant !== 3'b010) begin
      errors++; $display("FAIL early_hold: grant=%b, required 010", grant);
    end
    req = 3'b000;
    step();
    checks++;
    if (grant !== 3'b000 || o_busy !== 1'b0 || grant !== exp_grant()) begin
      errors++; $display("FAIL early_release: grant=%b busy=%b, required 000 0", grant, o_busy);
    end
    step();
    checks++;
    if (grant !== 3'b000 || o_busy !== 1'b0) begin
      errors++; $display("FAIL early_idle: grant=%b busy=%b, required 000 0", grant, o_busy);
    end
  endtask

  task automatic test_hold_only();
    req_data[191:128] = 64'h0123_4567_89AB_CDEF; req_mode[2] = 1'b1;
    req = 3'b100;
    for (int n = 0; n < 20; n++) begin
      if (n == 10) req_data[191:128] = 64'hFF00FF00FF00FF00;
      step();
      checks++;
      if (grant !== 3'b100 || o_disp_data !== m_data || o_disp_mode !== m_mode) begin
        errors++; $display("FAIL hold_only n%0d: grant=%b data=%h, required 100 %h", n, grant, o_disp_data, m_data);
      end
    end
    checks++;
    if (o_disp_data !== 64'hFF00FF00FF00FF00) begin
      errors++; $display("FAIL hold_follow: data=%h, required ff00ff00ff00ff00", o_disp_data);
    end
    req = 3'b000;
    step(); step();
  endtask

  task automatic test_async_reset();
    req = 3'b001;
    step(); step();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (grant !== 3'b000 || o_busy !== 1'b0) begin
      errors++; $display("FAIL async_reset: grant=%b busy=%b, required 000 0", grant, o_busy);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1; req = 3'b110;
    step();
    checks++;
    if (grant !== 3'b010 || grant !== exp_grant()) begin
      errors++; $display("FAIL reset_priority: grant=%b, required 010", grant);
    end
    req = 3'b000;
    step(); step();
  endtask

  task automatic test_blank();
    logic [63:0] lane;
    lane = 64'hDEAD_BEEF_0BAD_F00D;
    req_data[63:0] = lane; req_mode[0] = 1'b0; req = 3'b001;
    step(); step(); step();
    req = 3'b000;
    step();
    step();
    checks++;
`ifdef SEG7_ARB_BLANK_EN
    if (o_disp_data !== 64'hFFFF_FFFF_FFFF_FFFF || o_disp_mode !== 1'b1) begin
      errors++; $display("FAIL blank: data=%h mode=%b, required ffffffffffffffff 1", o_disp_data, o_disp_mode);
    end
`else
    if (o_disp_data !== lane || o_disp_mode !== 1'b0) begin
      errors++; $display("FAIL persist: data=%h mode=%b, required %h 0", o_disp_data, o_disp_mode, lane);
    end
`endif
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 3; i++) if ($urandom_range(0, 5) == 0) req[i] = ~req[i];
      req_mode = 3'($urandom);
      req_data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      step();
      checks++;
      if (grant !== exp_grant() || o_busy !== (m_owner >= 0) || o_disp_data !== m_data || o_disp_mode !== m_mode) begin
        errors++;
        $display("FAIL random n%0d: grant=%b busy=%b mode=%b data=%h, required %b %b %b %h",
                 n, grant, o_busy, o_disp_mode, o_disp_data, exp_grant(), (m_owner >= 0), m_mode, m_data);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; req = 3'b000; req_mode = 3'b000; req_data = '0;
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_early_release();
    test_hold_only();
    test_async_reset();
    test_blank();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
